// File: rtl/spi_master_sequencer.sv
// spi_master_sequencer: transaction sequencer for the SPI-master engine of the slave tester.
//   Latches the transfer config on start, waits the start delay, asserts cs_n, issues one
//   sym_start per symbol to the bit shifter (with optional inter-symbol gaps and half-duplex
//   direction), holds cs_n after the last symbol, then deasserts it and pulses done.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   start, abort      1-cycle requests (start ignored while busy, abort ignored in IDLE/FINISH)
//   num_of_sym        full-duplex symbol count
//   hd_mode           1 = half duplex (hd_tx_cnt TX symbols, then hd_rx_cnt RX symbols)
//   start_delay_us    idle delay before cs_n asserts, in microseconds
//   sym_delay         clk cycles between sym_done and the next sym_start
//   clk_div           sclk divider; setup = clk_div>>1, hold = clk_div - setup
//   sym_start/sym_dir 1-cycle shift request and its direction (1 = TX) to the shifter
//   sym_done          1-cycle symbol-complete pulse from the shifter
//   cs_n, busy, done  chip select (active low), busy flag, completion pulse
//   aborted           sticky: last transfer ended by abort
//   sym_index         symbols completed in the current transfer
module spi_master_sequencer #(
    parameter int CLK_PER_US = 100,
    parameter int CNT_BITS   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [CNT_BITS-1:0] num_of_sym,
    input  logic                hd_mode,
    input  logic [CNT_BITS-1:0] hd_tx_cnt,
    input  logic [CNT_BITS-1:0] hd_rx_cnt,
    input  logic [7:0]          start_delay_us,
    input  logic [CNT_BITS-1:0] sym_delay,
    input  logic [CNT_BITS-1:0] clk_div,
    output logic                sym_start,
    output logic                sym_dir,
    input  logic                sym_done,
    output logic                cs_n,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [CNT_BITS-1:0] sym_index
);
    typedef enum logic [2:0] {
        IDLE, START_DLY, CS_SETUP, SYM_ISSUE, SYM_WAIT, SYM_GAP, CS_HOLD, FINISH
    } state_t;

    state_t              state, nx;
    logic [31:0]         cnt, cnt_nx, dly_in, setup_c, hold_c;
    logic [CNT_BITS:0]   idx, idx_nx, total_in, total_q, total_c;
    logic [CNT_BITS-1:0] tx_q, tx_c, gap_q, gap_c, div_q, div_c;
    logic                hd_q, hd_c, pend, pend_nx, abort_set, latch, go_setup, go_hold;

    // In IDLE the config registers are not loaded yet, so the start cycle uses the live inputs.
    assign total_in = hd_mode ? {1'b0, hd_tx_cnt} + {1'b0, hd_rx_cnt} : {1'b0, num_of_sym};
    assign total_c  = (state == IDLE) ? total_in : total_q;
    assign hd_c     = (state == IDLE) ? hd_mode : hd_q;
    assign tx_c     = (state == IDLE) ? hd_tx_cnt : tx_q;
    assign gap_c    = (state == IDLE) ? sym_delay : gap_q;
    assign div_c    = (state == IDLE) ? clk_div : div_q;
    assign dly_in   = 32'(start_delay_us) * 32'(CLK_PER_US);
    assign setup_c  = 32'(div_c >> 1);
    assign hold_c   = 32'(div_c) - setup_c;
    assign sym_index = idx[CNT_BITS-1:0];

    // Wait states load cnt = n-1 and leave at 0, so each occupies exactly n cycles;
    // go_setup/go_hold skip the state entirely when its length is 0.
    always_comb begin
        nx        = state;
        cnt_nx    = cnt;
        idx_nx    = idx;
        latch     = 1'b0;
        go_setup  = 1'b0;
        go_hold   = 1'b0;
        abort_set = abort && !(state inside {IDLE, FINISH});
        pend_nx   = pend || abort_set;
        case (state)
            IDLE: if (start) begin
                latch    = 1'b1;
                idx_nx   = '0;
                pend_nx  = 1'b0;
                nx       = (total_c == '0) ? FINISH : START_DLY;
                cnt_nx   = dly_in - 32'(dly_in != 32'd0);
                go_setup = (total_c != '0) && (dly_in == 32'd0);
            end
            START_DLY: begin
                if (abort) nx = FINISH;
                else if (cnt != 32'd0) cnt_nx = cnt - 32'd1;
                else go_setup = 1'b1;
            end
            CS_SETUP: begin
                if (abort) go_hold = 1'b1;
                else if (cnt != 32'd0) cnt_nx = cnt - 32'd1;
                else nx = SYM_ISSUE;
            end
            SYM_ISSUE: nx = SYM_WAIT;
            // A pending or simultaneous abort lets the in-flight symbol finish and be counted.
            SYM_WAIT: if (sym_done) begin
                idx_nx = idx + {{CNT_BITS{1'b0}}, 1'b1};
                if (idx_nx == total_c || pend || abort) go_hold = 1'b1;
                else if (gap_c != '0) begin
                    nx     = SYM_GAP;
                    cnt_nx = 32'(gap_c) - 32'd1;
                end
                else nx = SYM_ISSUE;
            end
            SYM_GAP: begin
                if (abort) go_hold = 1'b1;
                else if (cnt != 32'd0) cnt_nx = cnt - 32'd1;
                else nx = SYM_ISSUE;
            end
            CS_HOLD: begin
                if (cnt != 32'd0) cnt_nx = cnt - 32'd1;
                else nx = FINISH;
            end
            default: nx = IDLE;
        endcase
        if (go_setup) begin
            nx     = (setup_c != 32'd0) ? CS_SETUP : SYM_ISSUE;
            cnt_nx = setup_c - 32'(setup_c != 32'd0);
        end
        if (go_hold) begin
            nx     = (hold_c != 32'd0) ? CS_HOLD : FINISH;
            cnt_nx = hold_c - 32'(hold_c != 32'd0);
        end
    end

    // Outputs are registered from the next state so they are glitch-free and aligned with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            pend      <= 1'b0;
            cs_n      <= 1'b1;
            sym_start <= 1'b0;
            sym_dir   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            total_q   <= '0;
            hd_q      <= 1'b0;
            tx_q      <= '0;
            gap_q     <= '0;
            div_q     <= '0;
        end else begin
            state     <= nx;
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            pend      <= pend_nx;
            cs_n      <= !(nx inside {CS_SETUP, SYM_ISSUE, SYM_WAIT, SYM_GAP, CS_HOLD});
            sym_start <= (nx == SYM_ISSUE);
            busy      <= (nx != IDLE);
            done      <= (nx == FINISH);
            if (nx == SYM_ISSUE) sym_dir <= hd_c ? (idx_nx < {1'b0, tx_c}) : 1'b1;
            if (latch) aborted <= 1'b0;
            else if (abort_set) aborted <= 1'b1;
            if (latch) begin
                total_q <= total_in;
                hd_q    <= hd_mode;
                tx_q    <= hd_tx_cnt;
                gap_q   <= sym_delay;
                div_q   <= clk_div;
            end
        end
    end
endmodule

// File: tb/tb_spi_master_sequencer.sv
// tb_spi_master_sequencer: directed bench for spi_master_sequencer with a shifter model.
module tb_spi_master_sequencer;
    localparam int CW = 16;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, hd_mode = 1'b0, sym_done = 1'b0;
    logic [CW-1:0] num_of_sym = '0, hd_tx_cnt = '0, hd_rx_cnt = '0, sym_delay = '0, clk_div = '0;
    logic [7:0] start_delay_us = '0;
    logic sym_start, sym_dir, cs_n, busy, done, aborted;
    logic [CW-1:0] sym_index;
    logic [31:0] dirv;
    int cyc = 0, n_chk = 0, n_pass = 0, lat = 79, model_cnt = 0;
    int n_start, n_done, cs_low, first_low, rise, last_done, done_cyc, gmin, gmax, t0;

    spi_master_sequencer #(.CLK_PER_US(100), .CNT_BITS(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_of_sym(num_of_sym),
        .hd_mode(hd_mode), .hd_tx_cnt(hd_tx_cnt), .hd_rx_cnt(hd_rx_cnt),
        .start_delay_us(start_delay_us), .sym_delay(sym_delay), .clk_div(clk_div),
        .sym_start(sym_start), .sym_dir(sym_dir), .sym_done(sym_done), .cs_n(cs_n),
        .busy(busy), .done(done), .aborted(aborted), .sym_index(sym_index)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shifter model: sym_done is high lat cycles after the sym_start cycle.
    initial forever begin
        @(posedge clk);
        #1;
        sym_done = (model_cnt == 1);
        if (model_cnt > 0) model_cnt--;
        if (sym_start) model_cnt = lat;
    end

    always @(negedge clk) begin
        if (sym_start) begin
            n_start++;
            dirv = {dirv[30:0], sym_dir};
            if (last_done >= 0) begin
                gmin = (cyc - last_done - 1 < gmin) ? cyc - last_done - 1 : gmin;
                gmax = (cyc - last_done - 1 > gmax) ? cyc - last_done - 1 : gmax;
            end
        end
        if (sym_done) last_done = cyc;
        if (!cs_n) begin
            cs_low++;
            if (first_low < 0) first_low = cyc;
        end
        else if (first_low >= 0 && rise < 0) rise = cyc;
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic cfg(input logic hd, input int n, input int tx, input int rx, input int dus,
                       input int div, input int gap, input int l);
        hd_mode = hd;
        num_of_sym = CW'(n);
        hd_tx_cnt = CW'(tx);
        hd_rx_cnt = CW'(rx);
        start_delay_us = 8'(dus);
        clk_div = CW'(div);
        sym_delay = CW'(gap);
        lat = l;
    endtask

    task automatic pulse_start();
        n_start = 0; n_done = 0; cs_low = 0; first_low = -1; rise = -1;
        last_done = -1; done_cyc = -1; gmin = 1 << 30; gmax = -1; dirv = '0;
        @(posedge clk);
        #1 start = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int tmo);
        int k = 0;
        while (n_done == 0 && k < tmo) begin
            @(posedge clk);
            k++;
        end
        chk(tag, int'(k < tmo), 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_starts(input int n, input int tmo);
        int k = 0;
        while (n_start < n && k < tmo) begin
            @(posedge clk);
            k++;
        end
        chk("wait_start", int'(n_start >= n), 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", int'(cs_n), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sym_start", int'(sym_start), 0);
        chk("rst_sym_dir", int'(sym_dir), 1);
        chk("rst_aborted", int'(aborted), 0);
        chk("rst_index", int'(sym_index), 0);
        rst = 1'b0;

        cfg(1'b0, 3, 0, 0, 1, 10, 0, 79);
        pulse_start();
        wait_done("t1_timeout", 2000);
        chk("t1_cs_high_pre", first_low - t0 - 1, 100);
        chk("t1_starts", n_start, 3);
        chk("t1_dirs", int'(dirv), 7);
        chk("t1_cs_low", cs_low, 250);
        chk("t1_done_cnt", n_done, 1);
        chk("t1_index", int'(sym_index), 3);
        chk("t1_gap_max", gmax, 0);
        chk("t1_busy_after", int'(busy), 0);

        cfg(1'b1, 0, 5, 5, 0, 2, 0, 3);
        pulse_start();
        wait_done("t2_timeout", 500);
        chk("t2_starts", n_start, 10);
        chk("t2_dirs", int'(dirv), 992);
        chk("t2_index", int'(sym_index), 10);
        chk("t2_cs_low", cs_low, 42);
        chk("t2_done_cnt", n_done, 1);

        cfg(1'b0, 0, 0, 0, 1, 4, 0, 3);
        pulse_start();
        wait_done("t3fd_timeout", 50);
        chk("t3fd_latency", done_cyc - t0, 1);
        chk("t3fd_cs_low", cs_low, 0);
        chk("t3fd_starts", n_start, 0);
        cfg(1'b1, 9, 0, 0, 1, 4, 0, 3);
        pulse_start();
        wait_done("t3hd_timeout", 50);
        chk("t3hd_latency", done_cyc - t0, 1);
        chk("t3hd_cs_low", cs_low, 0);
        chk("t3hd_starts", n_start, 0);

        cfg(1'b0, 3, 0, 0, 0, 4, 7, 3);
        pulse_start();
        wait_done("t4_timeout", 500);
        chk("t4_gap_min", gmin, 7);
        chk("t4_gap_max", gmax, 7);
        chk("t4_starts", n_start, 3);
        chk("t4_cs_low", cs_low, 30);

        cfg(1'b0, 5, 0, 0, 0, 4, 0, 20);
        pulse_start();
        wait_starts(2, 200);
        repeat (4) @(posedge clk);
        pulse_abort();
        wait_done("t5_timeout", 500);
        chk("t5_starts", n_start, 2);
        chk("t5_index", int'(sym_index), 2);
        chk("t5_aborted", int'(aborted), 1);
        chk("t5_hold", rise - last_done, 3);
        chk("t5_cs_low", cs_low, 46);

        cfg(1'b0, 5, 0, 0, 2, 4, 0, 3);
        pulse_start();
        repeat (10) @(posedge clk);
        pulse_abort();
        wait_done("t5dly_timeout", 500);
        chk("t5dly_cs_low", cs_low, 0);
        chk("t5dly_aborted", int'(aborted), 1);
        chk("t5dly_starts", n_start, 0);
        chk("t5dly_done_cnt", n_done, 1);

        cfg(1'b0, 1, 0, 0, 0, 1, 0, 3);
        pulse_start();
        wait_done("div1_timeout", 100);
        chk("div1_aborted_clr", int'(aborted), 0);
        chk("div1_cs_low", cs_low, 5);
        cfg(1'b0, 1, 0, 0, 0, 0, 0, 3);
        pulse_start();
        wait_done("div0_timeout", 100);
        chk("div0_cs_low", cs_low, 4);
        chk("div0_index", int'(sym_index), 1);

        cfg(1'b0, 4, 0, 0, 0, 4, 0, 50);
        pulse_start();
        wait_starts(1, 100);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_cs_n", int'(cs_n), 1);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_index", int'(sym_index), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (60) @(posedge clk);

        cfg(1'b0, 2, 0, 0, 0, 2, 0, 3);
        pulse_start();
        repeat (3) @(posedge clk);
        #1 num_of_sym = CW'(9);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("t6_timeout", 200);
        chk("t6_starts", n_start, 2);
        chk("t6_index", int'(sym_index), 2);
        chk("t6_done_cnt", n_done, 1);
        chk("t6_cs_low", cs_low, 10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
